// File: rtl/rx_ctrl_pkg.sv
// Shared types and sizing helpers for the UART receive control unit.
package rx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RECEIVE,
    STOP_SAMPLE,
    STOP_CHECK,
    STOP2_WAIT,
    PARITY_CHECK,
    LOAD
  } rx_state_e;

  localparam int BIT_TARGET_W = 4;

  // Width needed to count 0..limit inclusive; never narrower than one bit.
  function automatic int break_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rx_ctrl_unit_if.sv
// Signal bundle between the RX control unit and its peripherals
// (start detector, bit timer, stop/parity checkers, RX buffer, consumer).
interface rx_ctrl_unit_if;
  import rx_ctrl_pkg::*;

  logic                    start_bit_detected;
  logic                    packet_done;
  logic                    bit_tick;
  logic                    framing_error;
  logic                    parity_error;
  logic                    data_read;
  logic                    sbc_clear;
  logic                    sbc_enable;
  logic                    load_buffer;
  logic                    enable_timer;
  logic [BIT_TARGET_W-1:0] bit_target;
  logic                    data_ready;
  logic                    overrun_error;
  logic                    break_detected;

  // master: the control unit itself; slave: the surrounding datapath
  modport master (
    input  start_bit_detected, packet_done, bit_tick, framing_error,
           parity_error, data_read,
    output sbc_clear, sbc_enable, load_buffer, enable_timer, bit_target,
           data_ready, overrun_error, break_detected
  );

  modport slave (
    output start_bit_detected, packet_done, bit_tick, framing_error,
           parity_error, data_read,
    input  sbc_clear, sbc_enable, load_buffer, enable_timer, bit_target,
           data_ready, overrun_error, break_detected
  );

endinterface

// File: rtl/rx_status_tracker.sv
// Consumer-facing status: data_ready, sticky overrun, and the saturating
// consecutive-framing-error counter behind break_detected.
module rx_status_tracker
  import rx_ctrl_pkg::*;
#(
  parameter int BREAK_LIMIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_pulse,
  input  logic frame_err_pulse,
  input  logic data_read,
  output logic data_ready,
  output logic overrun_error,
  output logic break_detected
);

  localparam int                CNT_W     = break_cnt_w(BREAK_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(BREAK_LIMIT);

  logic             data_ready_q, data_ready_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] brk_cnt_q, brk_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      brk_cnt_q    <= '0;
    end else begin
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
      brk_cnt_q    <= brk_cnt_d;
    end
  end

  always_comb begin
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    brk_cnt_d    = brk_cnt_q;

    // A read coinciding with a load consumes the old byte, so no overrun.
    if (load_pulse) begin
      data_ready_d = 1'b1;
      if (data_read) overrun_d = 1'b0;
      else if (data_ready_q) overrun_d = 1'b1;
    end else if (data_read) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end

    if (load_pulse) brk_cnt_d = '0;
    else if (frame_err_pulse && (brk_cnt_q != CNT_LIMIT)) brk_cnt_d = brk_cnt_q + 1'b1;
  end

  assign data_ready     = data_ready_q;
  assign overrun_error  = overrun_q;
  assign break_detected = (brk_cnt_q == CNT_LIMIT);

endmodule

// File: rtl/rx_ctrl_unit.sv
// UART receive sequencer: start clear, timed data sampling, 1/2 stop checks,
// optional parity check (RX_PARITY_EN) and buffer load, plus status tracking.
module rx_ctrl_unit
  import rx_ctrl_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int BREAK_LIMIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  rx_ctrl_unit_if.master bus
);

  // state        | meaning
  // IDLE         | waiting for start edge
  // CLEAR        | reset stop-bit checker, start bit timer
  // RECEIVE      | timer sampling data bits until packet_done
  // STOP_SAMPLE  | strobe stop-bit checker
  // STOP_CHECK   | evaluate framing_error
  // STOP2_WAIT   | wait one bit period for the second stop bit
  // PARITY_CHECK | evaluate parity_error (RX_PARITY_EN only)
  // LOAD         | move shift register into RX buffer

  localparam bit TWO_STOP = (STOP_BITS == 2);

`ifdef RX_PARITY_EN
  localparam rx_state_e AFTER_STOP = PARITY_CHECK;
  assign bus.bit_target = BIT_TARGET_W'(DATA_BITS + 2);
`else
  localparam rx_state_e AFTER_STOP = LOAD;
  assign bus.bit_target = BIT_TARGET_W'(DATA_BITS + 1);
  logic unused_parity;
  assign unused_parity = bus.parity_error;
`endif

  rx_state_e state_q, state_d;
  logic      stop2_q, stop2_d;
  logic      frame_err_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stop2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stop2_q <= stop2_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    stop2_d          = stop2_q;
    bus.sbc_clear    = 1'b0;
    bus.sbc_enable   = 1'b0;
    bus.load_buffer  = 1'b0;
    bus.enable_timer = 1'b0;

    case (state_q)
      IDLE: if (bus.start_bit_detected) state_d = CLEAR;
      CLEAR: begin
        bus.sbc_clear    = 1'b1;
        bus.enable_timer = 1'b1;
        stop2_d          = 1'b0;
        state_d          = RECEIVE;
      end
      RECEIVE: begin
        bus.enable_timer = 1'b1;
        if (bus.packet_done) state_d = STOP_SAMPLE;
      end
      STOP_SAMPLE: begin
        bus.sbc_enable = 1'b1;
        state_d        = STOP_CHECK;
      end
      STOP_CHECK: begin
        if (bus.framing_error) state_d = IDLE;
        else if (TWO_STOP && !stop2_q) begin
          state_d = STOP2_WAIT;
          stop2_d = 1'b1;
        end else state_d = AFTER_STOP;
      end
      STOP2_WAIT: begin
        bus.enable_timer = 1'b1;
        if (bus.bit_tick) state_d = STOP_SAMPLE;
      end
`ifdef RX_PARITY_EN
      PARITY_CHECK: state_d = bus.parity_error ? IDLE : LOAD;
`else
      PARITY_CHECK: state_d = IDLE;
`endif
      LOAD: begin
        bus.load_buffer = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_err_pulse = (state_q == STOP_CHECK) && bus.framing_error;

  rx_status_tracker #(
    .BREAK_LIMIT(BREAK_LIMIT)
  ) u_status (
    .clk            (clk),
    .rst            (rst),
    .load_pulse     (state_q == LOAD),
    .frame_err_pulse(frame_err_pulse),
    .data_read      (bus.data_read),
    .data_ready     (bus.data_ready),
    .overrun_error  (bus.overrun_error),
    .break_detected (bus.break_detected)
  );

endmodule

// File: tb/tb_rx_ctrl_unit.sv
// Bench for rx_ctrl_unit: one-stop and two-stop instances, directed plus
// randomized frames checked against a frame-level status model.
module tb_rx_ctrl_unit;
  import rx_ctrl_pkg::*;

  localparam int LIMIT = 2;

  logic clk, rst;
  logic sel;
  logic start, pd, tick, fe, pe, rd;
  int   tests, fails;
  int   m_ready[2], m_ovr[2], m_brk[2];

  rx_ctrl_unit_if if1();
  rx_ctrl_unit_if if2();

  assign if1.start_bit_detected = start & ~sel;
  assign if1.packet_done        = pd    & ~sel;
  assign if1.bit_tick           = tick  & ~sel;
  assign if1.framing_error      = fe    & ~sel;
  assign if1.parity_error       = pe    & ~sel;
  assign if1.data_read          = rd    & ~sel;
  assign if2.start_bit_detected = start & sel;
  assign if2.packet_done        = pd    & sel;
  assign if2.bit_tick           = tick  & sel;
  assign if2.framing_error      = fe    & sel;
  assign if2.parity_error       = pe    & sel;
  assign if2.data_read          = rd    & sel;

  wire o_clr   = sel ? if2.sbc_clear      : if1.sbc_clear;
  wire o_en    = sel ? if2.sbc_enable     : if1.sbc_enable;
  wire o_load  = sel ? if2.load_buffer    : if1.load_buffer;
  wire o_tmr   = sel ? if2.enable_timer   : if1.enable_timer;
  wire o_ready = sel ? if2.data_ready     : if1.data_ready;
  wire o_ovr   = sel ? if2.overrun_error  : if1.overrun_error;
  wire o_brk   = sel ? if2.break_detected : if1.break_detected;

  rx_ctrl_unit #(.DATA_BITS(8), .STOP_BITS(1), .BREAK_LIMIT(LIMIT)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  rx_ctrl_unit #(.DATA_BITS(8), .STOP_BITS(2), .BREAK_LIMIT(LIMIT)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s (inst %0d): observed %0d, expected %0d", tag, sel, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_ready"}, 4'(o_ready), 4'(m_ready[sel]));
    chk({tag, "_ovr"},   4'(o_ovr),   4'(m_ovr[sel]));
    chk({tag, "_brk"},   4'(o_brk),   4'(m_brk[sel] == LIMIT));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_clr"},  4'(o_clr),  4'd0);
    chk({tag, "_en"},   4'(o_en),   4'd0);
    chk({tag, "_load"}, 4'(o_load), 4'd0);
    chk({tag, "_tmr"},  4'(o_tmr),  4'd0);
  endtask

  // Frame-level reference: outcome of a whole frame applied to the status.
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ready[i] = 0; m_ovr[i] = 0; m_brk[i] = 0;
    end
  endtask

  task automatic model_frame_err();
    if (m_brk[sel] < LIMIT) m_brk[sel]++;
  endtask

  task automatic model_load(input bit rd_same);
    if (rd_same) m_ovr[sel] = 0;
    else if (m_ready[sel] != 0) m_ovr[sel] = 1;
    m_ready[sel] = 1;
    m_brk[sel]   = 0;
  endtask

  task automatic do_read();
    rd = 1'b1;
    step();
    rd = 1'b0;
    m_ready[sel] = 0;
    m_ovr[sel]   = 0;
    chk_status("read");
  endtask

  task automatic frame(input bit fe1, input bit fe2, input bit pe_in, input bit rd_at_load);
    int n;
    pe    = pe_in;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("clear_pulse", 4'(o_clr), 4'd1);
    chk("clear_tmr",   4'(o_tmr), 4'd1);
    step();
    chk("clear_once",  4'(o_clr), 4'd0);
    n = $urandom_range(2, 6);
    for (int i = 0; i < n; i++) begin
      chk("recv_tmr", 4'(o_tmr), 4'd1);
      chk("recv_en",  4'(o_en),  4'd0);
      start = 1'($urandom_range(0, 1));
      tick  = 1'($urandom_range(0, 1));
      step();
    end
    start = 1'b0;
    tick  = 1'b0;
    chk("recv_stay", 4'(o_tmr), 4'd1);
    pd = 1'b1;
    step();
    pd = 1'b0;
    chk("stop_sample_en",  4'(o_en),  4'd1);
    chk("stop_sample_tmr", 4'(o_tmr), 4'd0);
    fe = fe1;
    step();
    chk("stop_check_en",   4'(o_en),   4'd0);
    chk("stop_check_load", 4'(o_load), 4'd0);
    step();
    fe = 1'b0;
    if (fe1) begin
      model_frame_err();
      chk_quiet("fe1_idle");
      chk_status("fe1");
      pe = 1'b0;
      return;
    end
    if (sel) begin
      chk("stop2_tmr", 4'(o_tmr), 4'd1);
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        step();
        chk("stop2_wait_tmr", 4'(o_tmr), 4'd1);
        chk("stop2_wait_en",  4'(o_en),  4'd0);
      end
      tick = 1'b1;
      step();
      tick = 1'b0;
      chk("stop2_sample_en", 4'(o_en), 4'd1);
      fe = fe2;
      step();
      chk("stop2_check_en", 4'(o_en), 4'd0);
      step();
      fe = 1'b0;
      if (fe2) begin
        model_frame_err();
        chk_quiet("fe2_idle");
        chk_status("fe2");
        pe = 1'b0;
        return;
      end
    end
`ifdef RX_PARITY_EN
    chk("parity_no_load", 4'(o_load), 4'd0);
    step();
    if (pe_in) begin
      chk_quiet("pe_idle");
      chk_status("pe");
      pe = 1'b0;
      return;
    end
`endif
    chk("load_pulse",       4'(o_load),  4'd1);
    chk("load_ready_prior", 4'(o_ready), 4'(m_ready[sel]));
    rd = rd_at_load;
    step();
    rd = 1'b0;
    pe = 1'b0;
    model_load(rd_at_load);
    chk("load_once", 4'(o_load), 4'd0);
    chk_status("load");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    sel   = 1'b0;
    {start, pd, tick, fe, pe, rd} = '0;
    model_reset();
    rst = 1'b1;
    step();
    step();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      chk_quiet("reset");
      chk_status("reset");
`ifdef RX_PARITY_EN
      chk("bit_target", (s == 0) ? if1.bit_target : if2.bit_target, 4'd10);
`else
      chk("bit_target", (s == 0) ? if1.bit_target : if2.bit_target, 4'd9);
`endif
    end
    rst = 1'b0;
    step();

    // one stop bit: good frame, overrun, read, read coinciding with load
    sel = 1'b0;
    frame(0, 0, 0, 0);
    frame(0, 0, 0, 0);
    do_read();
    frame(0, 0, 0, 0);
    frame(0, 0, 0, 1);
    // break on two framing errors, cleared by a good frame
    frame(1, 0, 0, 0);
    frame(1, 0, 0, 0);
    frame(1, 0, 0, 0);
    frame(0, 0, 0, 1);

    // two stop bits: error on the second check, then break and recovery
    sel = 1'b1;
    frame(0, 1, 0, 0);
    frame(0, 0, 0, 0);
    frame(0, 1, 0, 0);
    frame(1, 0, 0, 0);
    frame(0, 0, 0, 1);

`ifdef RX_PARITY_EN
    sel = 1'b0;
    frame(1, 0, 0, 0);
    frame(0, 0, 1, 0);
    frame(0, 0, 0, 0);
`endif

    // asynchronous reset in the middle of RECEIVE
    sel = 1'b0;
    frame(0, 0, 0, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("mid_recv_tmr", 4'(o_tmr), 4'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_quiet("async_rst");
    chk_status("async_rst");
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_quiet("post_rst_idle");
    end
    frame(0, 0, 0, 0);

    // randomized frames on both instances
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int k = 0; k < 15; k++) begin
        frame(($urandom_range(0, 3) == 0),
              (s == 1) && ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 2) == 0) do_read();
        repeat ($urandom_range(0, 2)) step();
        chk_quiet("gap_idle");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
